cpu_control_unit: RTL
=====================

// Module: cpu_control_unit
// PURPOSE
//  Multi-cycle sequencer for the 16-bit CPU Datapath (256x16 memory, 8x16 register file + ALU, PC).
//  Fetches, decodes and executes one instruction at a time.
//  Drives every Datapath control strobe and latches the ALU flags for conditional branches.
//  The top level ties mem_clk, rf_clk and pc_clk to clk; only the enables below qualify writes.
// PARAMETERS
//  INSTR_W   16  instruction / data width
//  ADDR_W    8   memory address width (pc_addr[ADDR_W-1:0])
//  HALT_ILL  1   1: illegal opcode enters HALT with illegal=1; 0: treated as NOP
// PORTS
//  clk          in   1   sole clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  start        in   1   IDLE->FETCH when high
//  instr        in   16  = Datapath mem_dataout
//  N,Z,V,C      in   1   Datapath ALU flags (combinational)
//  mem_wen      out  1   memory write strobe
//  mem_ren      out  1   selects mem_addr over pc as memory address
//  mem_addr     out  8   data address = IR[7:0]
//  rf_en        out  1   register-file write enable
//  rf_addr      out  3   write register = IR[10:8]
//  rf_op        out  2   00 alu_out, 01 mem_dataout, 10 pc_addr
//  rf_readA/B   out  3   read ports: IR[7:5] / IR[4:2]; ST and OUT read IR[10:8] on B / A
//  add0_sub1, LHI, LLI, ext_imm  out  1   ALU mode controls
//  ext_immB     out  16  {8'h00, IR[7:0]}
//  pc_en        out  1   PC update enable
//  pc_inc0_jum1 out  1   0: PC+1, 1: PC<=pc_ext
//  pc_ext       out  16  {8'h00, IR[7:0]} absolute jump target
//  ctro_outR    out  1   OutR load strobe
//  halted       out  1   high in HALT
//  illegal      out  1   sticky: illegal opcode seen
//  flags_q      out  4   latched {N,Z,V,C}
// BEHAVIOUR
//  Reset: state=IDLE; IR, flags_q, illegal = 0.
//   All outputs are decoded from (state, IR); in IDLE and HALT every strobe is 0.
//  Opcode = IR[15:11]:
//   00000 ADD; 00001 SUB; 00010 LHI; 00011 LLI; 00100 LD; 00101 ST; 00110 CMP; 01000 JMP;
//   01001 BZ; 01010 BN; 01011 JAL; 01100 OUT; 11111 HLT; all others illegal.
//  FSM states: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
//  IDLE:   -> FETCH when start.
//  FETCH:  memory address = pc; IR <= instr; pc_en=1, inc.
//  DECODE: readA/B valid.
//   LD/ST -> MEM; HLT -> HALT; illegal -> HALT if HALT_ILL, else FETCH; all others -> EXEC.
//  EXEC (1 cycle, then FETCH):
//   ADD/SUB: rf_en=1, rf_op=00; add0_sub1 = opcode[0]; flags_q <= {N,Z,V,C}.
//   CMP: SUB with rf_en=0; flags latched.
//   LHI/LLI: rf_en=1, ext_imm=1, LHI/LLI strobe; flags unchanged.
//   JMP: pc_en=1, jum1=1.
//   BZ/BN: jump only if flags_q Z/N = 1, else no PC update.
//   JAL: rf_en=1, rf_op=10 (writes PC+1), plus jump in the same cycle (RF samples old pc).
//   OUT: ctro_outR=1, readA=IR[10:8].
//  MEM: mem_ren=1, mem_addr=IR[7:0].
//   ST: mem_wen=1 with readB=IR[10:8]; -> FETCH.
//   LD: -> WB.
//  WB (LD): mem_ren=1, rf_en=1, rf_op=01; -> FETCH.
//  Latency: ALU/branch/OUT/ST 3 cycles; LD 4 cycles; HLT 2 cycles to HALT.
//  HALT: absorbing; only rst leaves it. start is ignored outside IDLE.
//  Branches use flags_q from the most recent ADD/SUB/CMP, never the live flags.
//  PC wraps 8'hFF -> 8'h00 (Datapath property; no controller action).
//  rst mid-instruction: IDLE next cycle. No strobe is asserted in the reset cycle's aftermath.
//   Datapath state (RF, PC) is reset by the shared reset, not by this block.
// STRUCTURE
//  Shared package cpu_pkg: opcode localparams, state encoding, rf_op codes (also used by assembler/bench).
//  One sub-module: cpu_decode (combinational IR -> class flags is_alu/is_ld/is_st/is_br/is_ill).
//  Top: state register, IR, flags_q, output decode.
// TESTING
//  1. rst, start; mem[0]=LLI r1,#5; mem[1]=LLI r2,#3; mem[2]=ADD r3,r1,r2; mem[3]=HLT
//     -> r3=8, halted after 11 cycles, pc=4.
//  2. SUB r3,r1,r1 then BZ #20 -> flags_q Z=1, pc=20.
//     Repeat with r1-r2 (5-3) -> no branch, pc=next.
//  3. ST r1,[0x80] then LD r4,[0x80] -> mem[0x80]=5, r4=5.
//     mem_wen high exactly 1 cycle; LD takes 4 cycles.
//  4. JAL r7,#0x10 at pc=6 -> r7=7, pc=0x10.
//     OUT r7 -> OutR=7, ctro_outR 1-cycle pulse.
//  5. Opcode 10101 with HALT_ILL=1 -> HALT, illegal=1, no rf_en/mem_wen.
//     With HALT_ILL=0 -> NOP, pc advances.
//  6. Assert rst during MEM of an ST -> no mem_wen in the next cycle, state IDLE, all outputs 0.
//     start re-fetches from pc=0.

Source files
------------

// File: rtl/cpu_control_unit_pkg.sv
// Shared CPU definitions: opcodes, controller states, RF write-source codes.
// Used by the controller, the assembler and the bench.
package cpu_pkg;
  localparam int CPU_INSTR_W = 16;
  localparam int CPU_ADDR_W  = 8;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_LHI = 5'b00010;
  localparam logic [4:0] OP_LLI = 5'b00011;
  localparam logic [4:0] OP_LD  = 5'b00100;
  localparam logic [4:0] OP_ST  = 5'b00101;
  localparam logic [4:0] OP_CMP = 5'b00110;
  localparam logic [4:0] OP_JMP = 5'b01000;
  localparam logic [4:0] OP_BZ  = 5'b01001;
  localparam logic [4:0] OP_BN  = 5'b01010;
  localparam logic [4:0] OP_JAL = 5'b01011;
  localparam logic [4:0] OP_OUT = 5'b01100;
  localparam logic [4:0] OP_HLT = 5'b11111;

  localparam logic [1:0] RF_ALU = 2'b00;
  localparam logic [1:0] RF_MEM = 2'b01;
  localparam logic [1:0] RF_PC  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef struct packed {
    logic is_alu;   // ADD, SUB, CMP: flag-producing ALU ops
    logic is_cmp;
    logic is_imm;
    logic is_ld;
    logic is_st;
    logic is_jmp;
    logic is_br;
    logic is_jal;
    logic is_out;
    logic is_hlt;
    logic is_ill;
  } dec_t;
endpackage

// File: rtl/cpu_control_unit_if.sv
// Controller <-> Datapath bundle: instruction/flags in, control strobes and status out.
interface cpu_control_unit_if;
  logic [cpu_pkg::CPU_INSTR_W-1:0] instr;
  logic                            N, Z, V, C;
  logic                            mem_wen, mem_ren;
  logic [cpu_pkg::CPU_ADDR_W-1:0]  mem_addr;
  logic                            rf_en;
  logic [2:0]                      rf_addr;
  logic [1:0]                      rf_op;
  logic [2:0]                      rf_readA, rf_readB;
  logic                            add0_sub1, LHI, LLI, ext_imm;
  logic [cpu_pkg::CPU_INSTR_W-1:0] ext_immB;
  logic                            pc_en, pc_inc0_jum1;
  logic [cpu_pkg::CPU_INSTR_W-1:0] pc_ext;
  logic                            ctro_outR, halted, illegal;
  logic [3:0]                      flags_q;

  modport master (
    input  instr, N, Z, V, C,
    output mem_wen, mem_ren, mem_addr, rf_en, rf_addr, rf_op, rf_readA, rf_readB,
           add0_sub1, LHI, LLI, ext_imm, ext_immB, pc_en, pc_inc0_jum1, pc_ext,
           ctro_outR, halted, illegal, flags_q
  );
  modport slave (
    output instr, N, Z, V, C,
    input  mem_wen, mem_ren, mem_addr, rf_en, rf_addr, rf_op, rf_readA, rf_readB,
           add0_sub1, LHI, LLI, ext_imm, ext_immB, pc_en, pc_inc0_jum1, pc_ext,
           ctro_outR, halted, illegal, flags_q
  );
endinterface

// File: rtl/cpu_control_unit_decode.sv
// Opcode -> instruction class flags; anything not listed is illegal.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output dec_t       dec
);
  always_comb begin
    dec = '0;
    case (opcode)
      OP_ADD, OP_SUB: dec.is_alu = 1'b1;
      OP_CMP:         begin dec.is_alu = 1'b1; dec.is_cmp = 1'b1; end
      OP_LHI, OP_LLI: dec.is_imm = 1'b1;
      OP_LD:          dec.is_ld  = 1'b1;
      OP_ST:          dec.is_st  = 1'b1;
      OP_JMP:         dec.is_jmp = 1'b1;
      OP_BZ, OP_BN:   dec.is_br  = 1'b1;
      OP_JAL:         dec.is_jal = 1'b1;
      OP_OUT:         dec.is_out = 1'b1;
      OP_HLT:         dec.is_hlt = 1'b1;
      default:        dec.is_ill = 1'b1;
    endcase
  end
endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit datapath.
// Owns IR, latched ALU flags and the sticky illegal bit; all strobes decode from (state, IR).
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int INSTR_W  = 16,
  parameter int ADDR_W   = 8,
  parameter bit HALT_ILL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  cpu_control_unit_if.master bus
);
  state_t             state, state_nx;
  logic [INSTR_W-1:0] ir;
  logic [3:0]         flags;
  logic               illegal;
  logic [4:0]         opcode;
  dec_t               dec;

  assign opcode = ir[INSTR_W-1 -: 5];

  cpu_decode u_decode (.opcode(opcode), .dec(dec));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ir      <= '0;
      flags   <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH) ir <= bus.instr;
      // Branches only ever see flags captured here, never the live ALU flags
      if (state == S_EXEC && dec.is_alu) flags <= {bus.N, bus.Z, bus.V, bus.C};
      if (state == S_DECODE && dec.is_ill) illegal <= 1'b1;
    end
  end

  // Fields taken straight from IR; ST and OUT name their source register in IR[10:8]
  assign bus.mem_addr = ir[ADDR_W-1:0];
  assign bus.rf_addr  = ir[10:8];
  assign bus.rf_readA = dec.is_out ? ir[10:8] : ir[7:5];
  assign bus.rf_readB = dec.is_st  ? ir[10:8] : ir[4:2];
  assign bus.ext_immB = {{(INSTR_W-8){1'b0}}, ir[7:0]};
  assign bus.pc_ext   = {{(INSTR_W-8){1'b0}}, ir[7:0]};
  assign bus.halted   = (state == S_HALT);
  assign bus.illegal  = illegal;
  assign bus.flags_q  = flags;

  always_comb begin
    state_nx         = state;
    bus.mem_wen      = 1'b0;
    bus.mem_ren      = 1'b0;
    bus.rf_en        = 1'b0;
    bus.rf_op        = RF_ALU;
    bus.add0_sub1    = 1'b0;
    bus.LHI          = 1'b0;
    bus.LLI          = 1'b0;
    bus.ext_imm      = 1'b0;
    bus.pc_en        = 1'b0;
    bus.pc_inc0_jum1 = 1'b0;
    bus.ctro_outR    = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_FETCH;
      S_FETCH: begin
        bus.pc_en = 1'b1;
        state_nx  = S_DECODE;
      end
      S_DECODE: begin
        if (dec.is_ld || dec.is_st) state_nx = S_MEM;
        else if (dec.is_hlt)        state_nx = S_HALT;
        else if (dec.is_ill)        state_nx = HALT_ILL ? S_HALT : S_FETCH;
        else                        state_nx = S_EXEC;
      end
      S_EXEC: begin
        state_nx = S_FETCH;
        if (dec.is_alu) begin
          bus.rf_en     = !dec.is_cmp;
          bus.add0_sub1 = opcode[0] | dec.is_cmp;
        end
        if (dec.is_imm) begin
          bus.rf_en   = 1'b1;
          bus.ext_imm = 1'b1;
          bus.LHI     = (opcode == OP_LHI);
          bus.LLI     = (opcode == OP_LLI);
        end
        if (dec.is_jmp ||
            (dec.is_br && ((opcode == OP_BZ && flags[2]) || (opcode == OP_BN && flags[3])))) begin
          bus.pc_en        = 1'b1;
          bus.pc_inc0_jum1 = 1'b1;
        end
        // JAL links the already-incremented PC while the jump lands on the same edge
        if (dec.is_jal) begin
          bus.rf_en        = 1'b1;
          bus.rf_op        = RF_PC;
          bus.pc_en        = 1'b1;
          bus.pc_inc0_jum1 = 1'b1;
        end
        if (dec.is_out) bus.ctro_outR = 1'b1;
      end
      S_MEM: begin
        bus.mem_ren = 1'b1;
        if (dec.is_st) begin
          bus.mem_wen = 1'b1;
          state_nx    = S_FETCH;
        end else begin
          state_nx = S_WB;
        end
      end
      S_WB: begin
        bus.mem_ren = 1'b1;
        bus.rf_en   = 1'b1;
        bus.rf_op   = RF_MEM;
        state_nx    = S_FETCH;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
  end
endmodule
